ycr_fpu_share_arb: RTL and testbench
====================================

# ycr_fpu_share_arb

Control-plane arbiter that shares the single clock-gated FPU between RISC-V core0 and core1. It sequences the FPU clock-gate request and wake-up wait, then round-robin arbitrates single-outstanding commands and routes each completion back to its owner. It releases the FPU clock request after a configurable idle period. The operand/result datapath muxing sits outside this block and is steered by `fpu_cmd_src`.

## Interface
- `WAKE_CYC`, 4: minimum cycles between `fpu_req` assertion and the first grant.
- `IDLE_CYC`, 16: idle cycles in ARB before `fpu_req` is dropped.
- `CNT_W`, 8: counter width. Both cycle parameters must be ≤ 2^CNT_W−1.
- `clk_in` in 1: FPU-domain clock, ungated.
- `reset` in 1: **asynchronous, active-high** reset.
- `cfg_force_on` in 1: 1 keeps `fpu_req` asserted and never returns to OFF.
- `core0_req_valid` in 1: core0 FPU command request. Held until `core0_req_ready`.
- `core0_req_ready` out 1: combinational accept pulse for core0.
- `core0_rsp_valid` out 1: registered 1-cycle completion pulse to core0.
- `core1_req_valid`, `core1_req_ready`, `core1_rsp_valid`: same as core0, for core1.
- `fpu_req` out 1: clock-gate request to the FPU clock gate.
- `fpu_clk_enb` in 1: clock-enable indication from the FPU clock gate.
- `fpu_idle` in 1: FPU reports idle.
- `fpu_cmd_valid` out 1: command valid to the FPU.
- `fpu_cmd_ready` in 1: FPU accepts the command.
- `fpu_cmd_src` out 1: owner of the current command (0 = core0, 1 = core1).
- `fpu_rsp_valid` in 1: FPU completion pulse.
- `err_unexp_rsp` out 1: sticky flag, set on `fpu_rsp_valid` outside BUSY.

## Operation
- States: OFF, WAKE, ARB, ISSUE, BUSY. Registers: `wake_cnt`, `idle_cnt`, `last_grant`, `owner`.
- OFF:
  - `fpu_req` = `cfg_force_on`.
  - If any `req_valid` is high, go to WAKE and load `wake_cnt` = WAKE_CYC.
- WAKE:
  - `fpu_req` = 1. `wake_cnt` decrements, saturating at 0.
  - Go to ARB when `wake_cnt` == 0 and `fpu_clk_enb` = 1. Stay in WAKE while `fpu_clk_enb` = 0.
- ARB:
  - `fpu_req` = 1. `idle_cnt` is loaded with IDLE_CYC on every entry.
  - If any request is present: pick the winner, register it in `owner`, go to ISSUE.
    - Both valid: the winner is the core ≠ `last_grant`.
    - One valid: that core wins.
  - Else `idle_cnt` decrements, saturating at 0.
  - Go to OFF when `idle_cnt` == 0, `fpu_idle` = 1 and `cfg_force_on` = 0.
  - A request always takes priority over the idle exit in the same cycle.
- ISSUE:
  - `fpu_cmd_valid` = 1. `fpu_cmd_src` = `owner`, held stable until ready.
  - `coreN_req_ready` = `fpu_cmd_ready` & (`owner` == N).
  - On `fpu_cmd_ready`: set `last_grant` = `owner`, go to BUSY.
- BUSY:
  - Wait for `fpu_rsp_valid`.
  - On `fpu_rsp_valid`: pulse `core[owner]_rsp_valid` the next cycle (registered), go to ARB.
  - Requests from either core are held off during BUSY.
- Only one command is outstanding at a time.
- `fpu_rsp_valid` in any state other than BUSY is ignored for routing and sets `err_unexp_rsp`. `err_unexp_rsp` clears only on reset.
- `fpu_clk_enb` is sampled only in WAKE. Deassertion in ARB, ISSUE or BUSY is ignored.
- `cfg_force_on` deasserted mid-operation takes effect only at the next ARB idle expiry.

## Timing
- Reset values:
  - State OFF. `fpu_req` = 0, `fpu_cmd_valid` = 0, `fpu_cmd_src` = 0.
  - All `req_ready` = 0, all `rsp_valid` = 0, `err_unexp_rsp` = 0.
  - `last_grant` = 1, so core0 wins the first tie.
  - Counters = 0.
- `fpu_req` is registered and follows the state, one cycle after the transition decision.
- Cold-start latency, with `fpu_clk_enb` already 1 and `core0_req_valid` rising in cycle 0:
  - WAKE during cycles 1..WAKE_CYC+1.
  - ARB in cycle WAKE_CYC+2.
  - `fpu_cmd_valid` = 1 from cycle WAKE_CYC+3.
- Warm latency: a request seen in ARB in cycle t gives `fpu_cmd_valid` in cycle t+1.
- Response latency: `fpu_rsp_valid` in cycle t gives `coreN_rsp_valid` in cycle t+1, with the state back in ARB.
- Idle release: ARB entered in cycle t with no requests and `fpu_idle` = 1 gives OFF, `fpu_req` = 0, in cycle t+IDLE_CYC+1. If `fpu_idle` = 0, the block stays in ARB with `idle_cnt` held at 0.
- Reset asserted mid-operation forces OFF immediately and drops all outputs. An in-flight FPU response after reset sets `err_unexp_rsp`.

## Test plan
- Cold start, WAKE_CYC = 4: `core0_req_valid` at cycle 0 with `fpu_clk_enb` = 1 -> `fpu_req` = 1 at cycle 1, `fpu_cmd_valid` at cycle 7, `fpu_cmd_src` = 0, `core0_req_ready` together with `fpu_cmd_ready`.
- Delayed clock enable: `fpu_clk_enb` rises at cycle 10 -> state stays WAKE, first `fpu_cmd_valid` at cycle 12.
- Contention: both cores request continuously for 6 commands -> grants alternate 0, 1, 0, 1, 0, 1, and each `rsp_valid` pulse goes only to the matching owner.
- Idle release, IDLE_CYC = 16: last response, then no requests with `fpu_idle` = 1 -> `fpu_req` falls exactly 17 cycles after ARB entry. With `cfg_force_on` = 1, `fpu_req` never falls.
- Simultaneous events:
  - `core1_req_valid` arrives in the same cycle `idle_cnt` hits 0 -> goes to ISSUE, not OFF.
  - `fpu_rsp_valid` during ISSUE -> `err_unexp_rsp` = 1 and stays set.
- Reset mid-BUSY: assert `reset` in BUSY -> all outputs 0 within the same cycle (asynchronous). The next tie is granted to core0.

Source files
------------

// File: rtl/ycr_fpu_share_arb_if.sv
// Control-plane bundle between the shared-FPU arbiter, the two cores and the
// FPU clock gate / command port.
//   master : arbiter side (drives ready/rsp pulses, fpu_req, fpu_cmd_*, err)
//   slave  : environment side (cores, FPU, clock gate, config)
interface ycr_fpu_share_arb_if;
    logic cfg_force_on;
    logic core0_req_valid;
    logic core0_req_ready;
    logic core0_rsp_valid;
    logic core1_req_valid;
    logic core1_req_ready;
    logic core1_rsp_valid;
    logic fpu_req;
    logic fpu_clk_enb;
    logic fpu_idle;
    logic fpu_cmd_valid;
    logic fpu_cmd_ready;
    logic fpu_cmd_src;
    logic fpu_rsp_valid;
    logic err_unexp_rsp;

    modport master (
        input  cfg_force_on,
        input  core0_req_valid,
        output core0_req_ready,
        output core0_rsp_valid,
        input  core1_req_valid,
        output core1_req_ready,
        output core1_rsp_valid,
        output fpu_req,
        input  fpu_clk_enb,
        input  fpu_idle,
        output fpu_cmd_valid,
        input  fpu_cmd_ready,
        output fpu_cmd_src,
        input  fpu_rsp_valid,
        output err_unexp_rsp
    );

    modport slave (
        output cfg_force_on,
        output core0_req_valid,
        input  core0_req_ready,
        input  core0_rsp_valid,
        output core1_req_valid,
        input  core1_req_ready,
        input  core1_rsp_valid,
        input  fpu_req,
        output fpu_clk_enb,
        output fpu_idle,
        input  fpu_cmd_valid,
        output fpu_cmd_ready,
        input  fpu_cmd_src,
        output fpu_rsp_valid,
        input  err_unexp_rsp
    );
endinterface

// File: rtl/ycr_fpu_share_arb.sv
// Shares one clock-gated FPU between core0 and core1: requests the FPU clock,
// waits for wake-up, round-robin grants single-outstanding commands, routes
// each completion to its owner and drops the clock request after idling.
// Ports:
//   clk_in  - ungated FPU-domain clock
//   reset   - asynchronous active-high reset
//   bus     - master side of ycr_fpu_share_arb_if (core handshakes, FPU
//             clock-gate request, FPU command/response, error flag)
module ycr_fpu_share_arb #(
    parameter int unsigned WAKE_CYC = 4,
    parameter int unsigned IDLE_CYC = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk_in,
    input  logic                reset,
    ycr_fpu_share_arb_if.master bus
);

    localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC);
    localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_OFF,
        S_WAKE,
        S_ARB,
        S_ISSUE,
        S_BUSY
    } state_e;

    state_e           state_q,      state_d;
    logic [CNT_W-1:0] wake_cnt_q,   wake_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q,   idle_cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q,      owner_d;
    logic             fpu_req_q,    fpu_req_d;
    logic             cmd_valid_q,  cmd_valid_d;
    logic             cmd_src_q,    cmd_src_d;
    logic             rsp0_q,       rsp0_d;
    logic             rsp1_q,       rsp1_d;
    logic             err_q,        err_d;
    logic             any_req;
    logic             winner;

    // State and output registers
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= S_OFF;
            wake_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            fpu_req_q    <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_src_q    <= 1'b0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wake_cnt_q   <= wake_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            fpu_req_q    <= fpu_req_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_src_q    <= cmd_src_d;
            rsp0_q       <= rsp0_d;
            rsp1_q       <= rsp1_d;
            err_q        <= err_d;
        end
    end

    // Next-state, counters, arbitration and registered-output inputs
    always_comb begin
        state_d      = state_q;
        wake_cnt_d   = wake_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;

        any_req = bus.core0_req_valid | bus.core1_req_valid;
        // On a tie the core that did not get the last grant wins
        if (bus.core0_req_valid && bus.core1_req_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = bus.core1_req_valid;
        end

        case (state_q)
            S_OFF: begin
                if (any_req) begin
                    state_d    = S_WAKE;
                    wake_cnt_d = WAKE_LD;
                end
            end
            S_WAKE: begin
                if (wake_cnt_q != '0) begin
                    wake_cnt_d = wake_cnt_q - CNT_ONE;
                end
                if (wake_cnt_q == '0 && bus.fpu_clk_enb) begin
                    state_d    = S_ARB;
                    idle_cnt_d = IDLE_LD;
                end
            end
            S_ARB: begin
                // A pending request beats the idle exit in the same cycle
                if (any_req) begin
                    owner_d = winner;
                    state_d = S_ISSUE;
                end else begin
                    if (idle_cnt_q != '0) begin
                        idle_cnt_d = idle_cnt_q - CNT_ONE;
                    end
                    if (idle_cnt_q == '0 && bus.fpu_idle && !bus.cfg_force_on) begin
                        state_d = S_OFF;
                    end
                end
            end
            S_ISSUE: begin
                if (bus.fpu_cmd_ready) begin
                    last_grant_d = owner_q;
                    state_d      = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.fpu_rsp_valid) begin
                    state_d    = S_ARB;
                    idle_cnt_d = IDLE_LD;
                end
            end
            default: begin
                state_d = S_OFF;
            end
        endcase

        // Outputs follow the state being entered so they line up with it
        fpu_req_d   = (state_d == S_OFF) ? bus.cfg_force_on : 1'b1;
        cmd_valid_d = (state_d == S_ISSUE);
        cmd_src_d   = (state_d == S_ISSUE) ? owner_d : 1'b0;
        rsp0_d      = (state_q == S_BUSY) && bus.fpu_rsp_valid && !owner_q;
        rsp1_d      = (state_q == S_BUSY) && bus.fpu_rsp_valid &&  owner_q;
        err_d       = err_q | (bus.fpu_rsp_valid && (state_q != S_BUSY));
    end

    // Accept pulse is combinational with the FPU's ready
    assign bus.core0_req_ready = (state_q == S_ISSUE) && bus.fpu_cmd_ready && !owner_q;
    assign bus.core1_req_ready = (state_q == S_ISSUE) && bus.fpu_cmd_ready &&  owner_q;

    assign bus.core0_rsp_valid = rsp0_q;
    assign bus.core1_rsp_valid = rsp1_q;
    assign bus.fpu_req         = fpu_req_q;
    assign bus.fpu_cmd_valid   = cmd_valid_q;
    assign bus.fpu_cmd_src     = cmd_src_q;
    assign bus.err_unexp_rsp   = err_q;

endmodule

// File: tb/tb_ycr_fpu_share_arb.sv
// Directed self-checking bench for ycr_fpu_share_arb with a grant/response
// scoreboard: the expected owner is queued when a command is handed to the
// FPU and popped when a completion pulse comes back.
module tb_ycr_fpu_share_arb;

    logic clk_in = 1'b0;
    logic reset;

    ycr_fpu_share_arb_if bus ();

    ycr_fpu_share_arb #(
        .WAKE_CYC (4),
        .IDLE_CYC (16),
        .CNT_W    (8)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int   n_chk  = 0;
    int   n_pass = 0;
    logic exp_q[$];
    logic mdl_last;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Step until the FPU sees a command, bounded
    task automatic wait_cmd(output int ncyc);
        ncyc = 0;
        while (bus.fpu_cmd_valid !== 1'b1 && ncyc < 64) begin
            step();
            ncyc++;
        end
        if (bus.fpu_cmd_valid !== 1'b1) check("cmd_timeout", bus.fpu_cmd_valid, 1);
    endtask

    // Handshake the command currently offered; expected owner goes to the scoreboard
    task automatic accept(input logic exp_src, input bit keep);
        check("cmd_src", bus.fpu_cmd_src, exp_src);
        exp_q.push_back(exp_src);
        bus.fpu_cmd_ready = 1'b1;
        #1;
        check("req_ready0", bus.core0_req_ready, !exp_src);
        check("req_ready1", bus.core1_req_ready, exp_src);
        mdl_last = exp_src;
        step();
        bus.fpu_cmd_ready = 1'b0;
        if (!keep) begin
            if (exp_src) bus.core1_req_valid = 1'b0;
            else         bus.core0_req_valid = 1'b0;
        end
        check("busy_cmd_valid", bus.fpu_cmd_valid, 0);
    endtask

    // Complete the outstanding command after dly BUSY cycles and check routing
    task automatic respond(input int dly);
        logic e;
        repeat (dly) step();
        bus.fpu_rsp_valid = 1'b1;
        step();
        bus.fpu_rsp_valid = 1'b0;
        e = 1'bx;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check("rsp_core0", bus.core0_rsp_valid, !e);
        check("rsp_core1", bus.core1_rsp_valid, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int first_req;
        int low;

        reset                 = 1'b1;
        bus.cfg_force_on      = 1'b0;
        bus.core0_req_valid   = 1'b0;
        bus.core1_req_valid   = 1'b0;
        bus.fpu_clk_enb       = 1'b1;
        bus.fpu_idle          = 1'b1;
        bus.fpu_cmd_ready     = 1'b0;
        bus.fpu_rsp_valid     = 1'b0;
        mdl_last              = 1'b1;

        // Reset state
        repeat (3) step();
        check("rst_fpu_req",   bus.fpu_req, 0);
        check("rst_cmd_valid", bus.fpu_cmd_valid, 0);
        check("rst_cmd_src",   bus.fpu_cmd_src, 0);
        check("rst_ready",     {bus.core1_req_ready, bus.core0_req_ready}, 0);
        check("rst_rsp",       {bus.core1_rsp_valid, bus.core0_rsp_valid}, 0);
        check("rst_err",       bus.err_unexp_rsp, 0);
        reset = 1'b0;

        // Cold start: core0 request in cycle 0
        bus.core0_req_valid = 1'b1;
        cyc = 0;
        first_req = -1;
        while (bus.fpu_cmd_valid !== 1'b1 && cyc < 64) begin
            step();
            cyc++;
            if (first_req < 0 && bus.fpu_req === 1'b1) first_req = cyc;
        end
        check("cold_fpu_req_cyc", first_req, 1);
        check("cold_cmd_cyc", cyc, 7);
        accept(1'b0, 1'b0);
        respond(2);

        // Warm request from core1 in ARB
        bus.core1_req_valid = 1'b1;
        step();
        check("warm_cmd_valid", bus.fpu_cmd_valid, 1);
        accept(1'b1, 1'b0);
        respond(0);

        // Idle release: fpu_req falls 17 cycles after ARB entry
        cyc = 0;
        while (bus.fpu_req === 1'b1 && cyc < 64) begin
            step();
            cyc++;
            if (cyc == 1) check("rsp_single_pulse", {bus.core1_rsp_valid, bus.core0_rsp_valid}, 0);
        end
        check("idle_release_cyc", cyc, 17);

        // Delayed clock enable rising in cycle 10
        bus.fpu_clk_enb     = 1'b0;
        bus.core0_req_valid = 1'b1;
        cyc = 0;
        while (bus.fpu_cmd_valid !== 1'b1 && cyc < 64) begin
            step();
            cyc++;
            if (cyc == 10) bus.fpu_clk_enb = 1'b1;
        end
        check("late_enb_cmd_cyc", cyc, 12);
        accept(1'b0, 1'b0);
        respond(1);

        // Request arrives as idle_cnt reaches 0: goes to ISSUE, not OFF
        repeat (16) step();
        bus.core1_req_valid = 1'b1;
        step();
        check("sim_req_fpu_req", bus.fpu_req, 1);
        check("sim_req_issue", bus.fpu_cmd_valid, 1);

        // Unexpected response during ISSUE
        bus.fpu_rsp_valid = 1'b1;
        step();
        bus.fpu_rsp_valid = 1'b0;
        check("err_set", bus.err_unexp_rsp, 1);
        check("err_no_route", {bus.core1_rsp_valid, bus.core0_rsp_valid}, 0);
        check("err_still_issue", bus.fpu_cmd_valid, 1);
        accept(1'b1, 1'b0);
        respond(0);
        check("err_sticky", bus.err_unexp_rsp, 1);

        // Reset in BUSY drops every output asynchronously
        bus.core0_req_valid = 1'b1;
        step();
        accept(1'b0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check("rbusy_fpu_req",   bus.fpu_req, 0);
        check("rbusy_cmd_valid", bus.fpu_cmd_valid, 0);
        check("rbusy_cmd_src",   bus.fpu_cmd_src, 0);
        check("rbusy_ready",     {bus.core1_req_ready, bus.core0_req_ready}, 0);
        check("rbusy_rsp",       {bus.core1_rsp_valid, bus.core0_rsp_valid}, 0);
        check("rbusy_err",       bus.err_unexp_rsp, 0);
        exp_q.delete();
        mdl_last = 1'b1;
        step();
        reset = 1'b0;

        // In-flight response arriving after reset
        bus.fpu_rsp_valid = 1'b1;
        step();
        bus.fpu_rsp_valid = 1'b0;
        check("err_after_reset", bus.err_unexp_rsp, 1);
        check("no_route_after_reset", {bus.core1_rsp_valid, bus.core0_rsp_valid}, 0);

        // Contention: grants alternate starting with core0
        bus.core0_req_valid = 1'b1;
        bus.core1_req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_cmd(cyc);
            check("rr_grant_seq", bus.fpu_cmd_src, i % 2);
            accept(~mdl_last, 1'b1);
            respond(i % 3);
        end
        bus.core0_req_valid = 1'b0;
        bus.core1_req_valid = 1'b0;

        // Forced-on: fpu_req never falls
        bus.cfg_force_on = 1'b1;
        low = 0;
        repeat (40) begin
            step();
            if (bus.fpu_req !== 1'b1) low++;
        end
        check("force_on_hold", low, 0);
        check("force_on_no_cmd", bus.fpu_cmd_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
